// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling PIPO buffer.
package pool_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_REG_NUM    = 20;
  localparam int MAXW           = 64;

  typedef logic signed [DEF_DATA_WIDTH-1:0] lane_t;
  typedef lane_t row_t [DEF_REG_NUM];

  // Signed max on a wide container; callers sign-extend into MAXW bits
  // and truncate back, so it serves any lane width up to MAXW.
  function automatic logic signed [MAXW-1:0] smax(
    input logic signed [MAXW-1:0] a,
    input logic signed [MAXW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipo_bank.sv
// One row of REG_NUM lane registers: synchronous clear, load (overwrite)
// and merge (lane-wise signed max with the incoming row).
module pipo_bank #(
  parameter int DATA_WIDTH = pool_pkg::DEF_DATA_WIDTH,
  parameter int REG_NUM    = pool_pkg::DEF_REG_NUM
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  merge,
  input  logic [DATA_WIDTH-1:0] din [REG_NUM],
  output logic [DATA_WIDTH-1:0] q   [REG_NUM]
);
  import pool_pkg::*;

  // Clear wins over load, load wins over merge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_NUM; i++) begin
      if (clr)
        q[i] <= '0;
      else if (load)
        q[i] <= din[i];
      else if (merge)
        q[i] <= DATA_WIDTH'(smax(MAXW'(signed'(q[i])), MAXW'(signed'(din[i]))));
    end
  end

endmodule

// File: rtl/pipo_pool_buf.sv
// Multi-bank ping-pong PIPO between pooling window and write-back stages.
// NUM_BANKS row banks used as a ring; valid/ready on both sides so one
// bank fills while another drains.
// Optional: PIPO_POOL_MAX_MERGE_EN adds in_last and vertical max merging
// of successive rows into the open bank before it commits.
module pipo_pool_buf #(
  parameter int DATA_WIDTH = pool_pkg::DEF_DATA_WIDTH,
  parameter int REG_NUM    = pool_pkg::DEF_REG_NUM,
  parameter int NUM_BANKS  = 2
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          in_valid,
`ifdef PIPO_POOL_MAX_MERGE_EN
  input  logic                          in_last,
`endif
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data  [REG_NUM],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data [REG_NUM],
  output logic [$clog2(NUM_BANKS+1)-1:0] count
);
  localparam int PW = $clog2(NUM_BANKS);
  localparam int CW = $clog2(NUM_BANKS+1);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop, commit;
  logic                  bank_clr;
  logic [NUM_BANKS-1:0]  bank_load, bank_merge;
  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS][REG_NUM];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_BANKS-1)) ? '0 : p + PW'(1);
  endfunction

  // Ready looks only at registered count; a same-cycle pop does not free a slot.
  assign in_ready  = (count < CW'(NUM_BANKS));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign bank_clr  = ~nrst;

`ifdef PIPO_POOL_MAX_MERGE_EN
  // Set once the bank at wr_ptr has taken its first row.
  logic open_q;

  assign commit = push && in_last;

  // First row into a fresh bank overwrites, later rows merge.
  always_comb begin
    bank_load          = '0;
    bank_merge         = '0;
    bank_load[wr_ptr]  = push && !open_q;
    bank_merge[wr_ptr] = push && open_q;
  end

  // Open flag tracks the partially merged bank.
  always_ff @(posedge clk) begin
    if (!nrst)       open_q <= 1'b0;
    else if (commit) open_q <= 1'b0;
    else if (push)   open_q <= 1'b1;
  end
`else
  assign commit = push;

  // Every push overwrites the bank at wr_ptr and commits.
  always_comb begin
    bank_load         = '0;
    bank_merge        = '0;
    bank_load[wr_ptr] = push;
  end
`endif

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (commit) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      if (commit && !pop)      count <= count + CW'(1);
      else if (!commit && pop) count <= count - CW'(1);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    pipo_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_NUM    (REG_NUM)
    ) u_bank (
      .clk   (clk),
      .clr   (bank_clr),
      .load  (bank_load[b]),
      .merge (bank_merge[b]),
      .din   (in_data),
      .q     (bank_q[b])
    );
  end

  // Head bank out through a mux, forced to zero when nothing is committed.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++)
      out_data[i] = (count != '0) ? bank_q[rd_ptr][i] : '0;
  end

endmodule

// File: tb/tb_pipo_pool_buf.sv
// Bench for pipo_pool_buf: default instance (16b x 20 lanes, 2 banks) and a
// narrow deep instance (8b x 4 lanes, 4 banks), each against a queue model.
module tb_pipo_pool_buf;
  localparam int DW = 16, RN = 20, NB = 2;
  localparam int DW1 = 8, RN1 = 4, NB1 = 4;

  typedef logic [DW-1:0]  row0_t [RN];
  typedef logic [DW1-1:0] row1_t [RN1];

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid0 = 1'b0, out_ready0 = 1'b0, in_ready0, out_valid0;
  logic [1:0]    count0;
  logic [DW-1:0] in_data0 [RN];
  logic [DW-1:0] out_data0 [RN];

  logic           in_valid1 = 1'b0, out_ready1 = 1'b0, in_ready1, out_valid1;
  logic [2:0]     count1;
  logic [DW1-1:0] in_data1 [RN1];
  logic [DW1-1:0] out_data1 [RN1];

`ifdef PIPO_POOL_MAX_MERGE_EN
  logic in_last0 = 1'b1, in_last1 = 1'b1;
`endif

  pipo_pool_buf u_dut0 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid0),
`ifdef PIPO_POOL_MAX_MERGE_EN
    .in_last(in_last0),
`endif
    .in_ready(in_ready0), .in_data(in_data0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_data(out_data0), .count(count0)
  );

  pipo_pool_buf #(.DATA_WIDTH(DW1), .REG_NUM(RN1), .NUM_BANKS(NB1)) u_dut1 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid1),
`ifdef PIPO_POOL_MAX_MERGE_EN
    .in_last(in_last1),
`endif
    .in_ready(in_ready1), .in_data(in_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .count(count1)
  );

  // Reference model: committed rows as FIFO queues, plus the open merge row.
  row0_t mq0[$];
  row1_t mq1[$];
  row0_t acc0;
  bit    open0 = 0;

  int checks = 0;
  int failures = 0;

  function automatic row0_t exp0();
    row0_t r;
    for (int i = 0; i < RN; i++) r[i] = (mq0.size() != 0) ? mq0[0][i] : '0;
    return r;
  endfunction

  function automatic row1_t exp1();
    row1_t r;
    for (int i = 0; i < RN1; i++) r[i] = (mq1.size() != 0) ? mq1[0][i] : '0;
    return r;
  endfunction

  function automatic bit diff0(input row0_t a, input row0_t b);
    for (int i = 0; i < RN; i++) if (a[i] !== b[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit diff1(input row1_t a, input row1_t b);
    for (int i = 0; i < RN1; i++) if (a[i] !== b[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock, updating the model with what the buffer must accept.
  task automatic step();
    bit p0, q0, p1, q1;
    p0 = in_valid0 && (mq0.size() < NB);
    q0 = out_ready0 && (mq0.size() != 0);
    p1 = in_valid1 && (mq1.size() < NB1);
    q1 = out_ready1 && (mq1.size() != 0);
    @(posedge clk);
    if (!nrst) begin
      mq0.delete(); mq1.delete(); open0 = 0;
    end else begin
      if (q0) void'(mq0.pop_front());
      if (q1) void'(mq1.pop_front());
      if (p0) begin
`ifdef PIPO_POOL_MAX_MERGE_EN
        for (int i = 0; i < RN; i++)
          if (!open0 || ($signed(in_data0[i]) > $signed(acc0[i]))) acc0[i] = in_data0[i];
        if (in_last0) begin mq0.push_back(acc0); open0 = 0; end
        else open0 = 1;
`else
        mq0.push_back(in_data0);
`endif
      end
      if (p1) mq1.push_back(in_data1);
    end
    #1;
  endtask

  task automatic rand_row0();
    for (int i = 0; i < RN; i++) in_data0[i] = DW'($urandom);
  endtask

  task automatic test_reset();
    nrst = 1'b0; step(); step(); nrst = 1'b1;
    checks++; if (count0 !== 2'd0) begin failures++; $display("FAIL reset_count got %0d want 0", count0); end
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready0); end
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid0); end
    checks++; if (diff0(out_data0, exp0())) begin failures++; $display("FAIL reset_out_data lane0 got %h want 0", out_data0[0]); end
    checks++; if (count1 !== 3'd0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL reset_wide count got %0d ready %b want 0 1", count1, in_ready1); end
  endtask

  task automatic test_fill_pop();
    row0_t a, b, c;
    for (int i = 0; i < RN; i++) begin a[i] = DW'(i + 1); b[i] = DW'(i + 21); c[i] = 16'hBEEF; end
    in_valid0 = 1'b1; in_data0 = a; step();
    in_data0 = b; step();
    checks++; if (count0 !== 2'd2 || in_ready0 !== 1'b0) begin failures++; $display("FAIL full_state count %0d ready %b want 2 0", count0, in_ready0); end
    in_data0 = c; step(); in_valid0 = 1'b0;
    checks++; if (count0 !== 2'd2) begin failures++; $display("FAIL full_blocked count got %0d want 2", count0); end
    checks++; if (diff0(out_data0, a)) begin failures++; $display("FAIL pop_a lane0 got %h want %h", out_data0[0], a[0]); end
    checks++; if (out_valid0 !== 1'b1) begin failures++; $display("FAIL pop_valid1 got %b want 1", out_valid0); end
    out_ready0 = 1'b1; step();
    checks++; if (out_valid0 !== 1'b1 || diff0(out_data0, b)) begin failures++; $display("FAIL pop_b valid %b lane0 got %h want %h", out_valid0, out_data0[0], b[0]); end
    step(); out_ready0 = 1'b0;
    checks++; if (out_valid0 !== 1'b0 || count0 !== 2'd0 || diff0(out_data0, exp0())) begin failures++; $display("FAIL pop_empty valid %b count %0d lane0 %h want 0 0 0", out_valid0, count0, out_data0[0]); end
  endtask

  task automatic test_back_to_back();
    in_valid0 = 1'b1; rand_row0(); step();
    out_ready0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rand_row0(); step();
      checks++; if (count0 !== 2'd1) begin failures++; $display("FAIL b2b_count[%0d] got %0d want 1", k, count0); end
      checks++; if (diff0(out_data0, exp0())) begin failures++; $display("FAIL b2b_data[%0d] lane0 got %h want %h", k, out_data0[0], mq0[0][0]); end
    end
    in_valid0 = 1'b0; step(); out_ready0 = 1'b0;
    checks++; if (count0 !== 2'd0) begin failures++; $display("FAIL b2b_drain count got %0d want 0", count0); end
  endtask

  task automatic test_stall();
    row0_t r;
    in_valid0 = 1'b1; rand_row0(); r = in_data0; step(); in_valid0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_row0(); step();
      checks++; if (diff0(out_data0, r) || count0 !== 2'd1) begin failures++; $display("FAIL stall[%0d] lane0 got %h want %h count %0d", k, out_data0[0], r[0], count0); end
    end
    out_ready0 = 1'b1; step(); out_ready0 = 1'b0;
  endtask

  task automatic test_wide();
    row1_t first;
    in_valid1 = 1'b1;
    for (int k = 0; k < NB1; k++) begin
      in_data1[0] = 8'h7F; in_data1[1] = 8'h80;
      for (int i = 2; i < RN1; i++) in_data1[i] = DW1'($urandom);
      if (k == 0) first = in_data1;
      step();
    end
    in_valid1 = 1'b0;
    checks++; if (count1 !== 3'd4 || in_ready1 !== 1'b0) begin failures++; $display("FAIL wide_full count %0d ready %b want 4 0", count1, in_ready1); end
    checks++; if (diff1(out_data1, first) || out_data1[1] !== 8'h80) begin failures++; $display("FAIL wide_first lane0 %h lane1 %h want 7f 80", out_data1[0], out_data1[1]); end
    out_ready1 = 1'b1;
    for (int k = 0; k < NB1; k++) begin
      checks++; if (diff1(out_data1, exp1())) begin failures++; $display("FAIL wide_pop[%0d] lane2 got %h want %h", k, out_data1[2], mq1[0][2]); end
      step();
    end
    out_ready1 = 1'b0;
    checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL wide_empty valid got %b want 0", out_valid1); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 120; k++) begin
      in_valid0 = 1'($urandom); out_ready0 = 1'($urandom); rand_row0();
      in_valid1 = 1'($urandom); out_ready1 = 1'($urandom);
      for (int i = 0; i < RN1; i++) in_data1[i] = DW1'($urandom);
`ifdef PIPO_POOL_MAX_MERGE_EN
      in_last0 = 1'($urandom);
`endif
      step();
      checks++; if (count0 !== 2'(mq0.size()) || in_ready0 !== (mq0.size() < NB) || out_valid0 !== (mq0.size() != 0))
        begin failures++; $display("FAIL rnd_ctl[%0d] count %0d ready %b valid %b want count %0d", k, count0, in_ready0, out_valid0, mq0.size()); end
      checks++; if (diff0(out_data0, exp0())) begin failures++; $display("FAIL rnd_data[%0d] lane0 got %h", k, out_data0[0]); end
      checks++; if (count1 !== 3'(mq1.size()) || diff1(out_data1, exp1()))
        begin failures++; $display("FAIL rnd_wide[%0d] count %0d want %0d lane0 %h", k, count1, mq1.size(), out_data1[0]); end
    end
    in_valid0 = 1'b0; out_ready0 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
`ifdef PIPO_POOL_MAX_MERGE_EN
    in_last0 = 1'b1;
`endif
  endtask

  task automatic test_reset_mid();
    in_valid0 = 1'b1;
    while (mq0.size() < NB) begin rand_row0(); step(); end
    in_valid0 = 1'b0;
    checks++; if (count0 !== 2'd2) begin failures++; $display("FAIL mid_pre count got %0d want 2", count0); end
    nrst = 1'b0; step(); nrst = 1'b1;
    checks++; if (count0 !== 2'd0 || out_valid0 !== 1'b0 || in_ready0 !== 1'b1)
      begin failures++; $display("FAIL mid_reset count %0d valid %b ready %b want 0 0 1", count0, out_valid0, in_ready0); end
    checks++; if (diff0(out_data0, exp0())) begin failures++; $display("FAIL mid_reset_data lane0 got %h want 0", out_data0[0]); end
  endtask

`ifdef PIPO_POOL_MAX_MERGE_EN
  task automatic test_merge();
    logic signed [DW-1:0] vals [3];
    vals[0] = -16'sd3; vals[1] = 16'sd7; vals[2] = 16'sd2;
    in_valid0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_row0(); in_data0[0] = vals[k]; in_last0 = (k == 2); step();
      if (k < 2) begin
        checks++; if (count0 !== 2'd0) begin failures++; $display("FAIL merge_open[%0d] count got %0d want 0", k, count0); end
      end
    end
    checks++; if (count0 !== 2'd1 || out_data0[0] !== 16'd7) begin failures++; $display("FAIL merge_commit count %0d lane0 %h want 1 0007", count0, out_data0[0]); end
    checks++; if (diff0(out_data0, exp0())) begin failures++; $display("FAIL merge_row lane1 got %h want %h", out_data0[1], mq0[0][1]); end
    rand_row0(); in_data0[0] = -16'sd5; in_last0 = 1'b1; step(); in_valid0 = 1'b0;
    out_ready0 = 1'b1; step(); out_ready0 = 1'b0;
    checks++; if (out_data0[0] !== 16'hFFFB || diff0(out_data0, exp0())) begin failures++; $display("FAIL merge_fresh lane0 got %h want fffb", out_data0[0]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < RN; i++) in_data0[i] = '0;
    for (int i = 0; i < RN1; i++) in_data1[i] = '0;
    for (int i = 0; i < RN; i++) acc0[i] = '0;
    test_reset();
    test_fill_pop();
    test_back_to_back();
    test_stall();
    test_wide();
    test_random();
    test_reset_mid();
`ifdef PIPO_POOL_MAX_MERGE_EN
    test_merge();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
